// File: rtl/ltc6912_pkg.sv
// Shared types and constants for the LTC6912 gain-control path.
// Gain codes follow the LTC6912 nibble encoding; bit 3 requests software shutdown.
package ltc6912_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_MEASURE,
        ST_DECIDE,
        ST_SEND,
        ST_SETTLE
    } agc_state_t;

    localparam logic [3:0] GAIN_0   = 4'd0;
    localparam logic [3:0] GAIN_1   = 4'd1;
    localparam logic [3:0] GAIN_2   = 4'd2;
    localparam logic [3:0] GAIN_5   = 4'd3;
    localparam logic [3:0] GAIN_10  = 4'd4;
    localparam logic [3:0] GAIN_20  = 4'd5;
    localparam logic [3:0] GAIN_50  = 4'd6;
    localparam logic [3:0] GAIN_100 = 4'd7;
    localparam logic [3:0] SHUTDOWN = 4'd8;

    // The shutdown bit is always masked so the amplifier is never powered down.
    function automatic logic [7:0] pack_gain(input logic [3:0] code_b, input logic [3:0] code_a);
        return {code_b & ~SHUTDOWN, code_a & ~SHUTDOWN};
    endfunction

endpackage

// File: rtl/ltc6912_agc_if.sv
// Valid/ready link carrying the packed gain byte from the AGC to the SPI driver.
interface ltc6912_agc_if;
    logic [7:0] gain_val;
    logic       gain_valid;
    logic       gain_ready;

    modport master (output gain_val, output gain_valid, input gain_ready);
    modport slave  (input gain_val, input gain_valid, output gain_ready);
endinterface

// File: rtl/ltc6912_peak_detect.sv
// Running peak of |sample| for one channel; the most negative code saturates
// to the largest positive magnitude.
module ltc6912_peak_detect #(
    parameter int SAMPLE_W = 12
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic        [SAMPLE_W-2:0] peak
);

    // For negative inputs the two's-complement negation fits in SAMPLE_W-1 bits,
    // except for the minimum code which wraps to zero and is caught explicitly.
    function automatic logic [SAMPLE_W-2:0] abs_sat(input logic signed [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-2:0] low;
        low = s[SAMPLE_W-2:0];
        if (s[SAMPLE_W-1] && (low == '0))
            return '1;
        if (s[SAMPLE_W-1])
            return ~low + 1'b1;
        return low;
    endfunction

    logic [SAMPLE_W-2:0] mag;

    assign mag = abs_sat(sample);

    always_ff @(posedge clk) begin
        if (clr)
            peak <= '0;
        else if (en && (mag > peak))
            peak <= mag;
    end

endmodule

// File: rtl/ltc6912_agc.sv
// Two-channel AGC: windowed peak measurement, one-step gain decisions, gain byte
// hand-off to the LTC6912 driver, and a settle interval after every update.
module ltc6912_agc
    import ltc6912_pkg::*;
#(
    parameter int         SAMPLE_W    = 12,
    parameter int         WINDOW      = 1024,
    parameter int         HIGH_THRESH = 1800,
    parameter int         LOW_THRESH  = 400,
    parameter int         SETTLE      = 64,
    parameter logic [3:0] INIT_CODE   = GAIN_1,
    parameter logic [3:0] MIN_CODE    = GAIN_1,
    parameter logic [3:0] MAX_CODE    = GAIN_100
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_a,
    input  logic signed [SAMPLE_W-1:0] sample_b,
    ltc6912_agc_if.master              gain,
    output logic        [3:0]          code_a,
    output logic        [3:0]          code_b,
    output logic        [SAMPLE_W-2:0] peak_a,
    output logic        [SAMPLE_W-2:0] peak_b,
    output logic                       update
);

    localparam int CNT_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]    WIN_LAST    = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [SAMPLE_W-2:0] HI_T        = (SAMPLE_W-1)'(HIGH_THRESH);
    localparam logic [SAMPLE_W-2:0] LO_T        = (SAMPLE_W-1)'(LOW_THRESH);

    function automatic logic [3:0] step_code(input logic [SAMPLE_W-2:0] pk, input logic [3:0] c);
        if ((pk >= HI_T) && (c > MIN_CODE))
            return c - 4'd1;
        if ((pk < LO_T) && (c < MAX_CODE))
            return c + 4'd1;
        return c;
    endfunction

    agc_state_t          state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [SAMPLE_W-2:0] acc_a, acc_b;
    logic [3:0]          nx_a, nx_b;
    logic                acc_en, acc_clr, counting, cnt_done;

    assign counting = (state == ST_MEASURE) || (state == ST_SETTLE);
    assign cnt_done = sample_valid &&
                      (((state == ST_MEASURE) && (cnt == WIN_LAST)) ||
                       ((state == ST_SETTLE)  && (cnt == SETTLE_LAST)));
    assign acc_en   = (state == ST_MEASURE) && sample_valid;
    assign acc_clr  = reset || (state == ST_INIT) || (state == ST_DECIDE) ||
                      ((state == ST_SETTLE) && cnt_done);
    assign nx_a     = step_code(acc_a, code_a);
    assign nx_b     = step_code(acc_b, code_b);

    ltc6912_peak_detect #(.SAMPLE_W(SAMPLE_W)) u_peak_a (
        .clk    (clk),
        .clr    (acc_clr),
        .en     (acc_en),
        .sample (sample_a),
        .peak   (acc_a)
    );

    ltc6912_peak_detect #(.SAMPLE_W(SAMPLE_W)) u_peak_b (
        .clk    (clk),
        .clr    (acc_clr),
        .en     (acc_en),
        .sample (sample_b),
        .peak   (acc_b)
    );

    always_comb begin
        state_nx        = state;
        gain.gain_valid = 1'b0;
        gain.gain_val   = 8'h00;
        case (state)
            ST_INIT:    state_nx = ST_SEND;
            ST_MEASURE: if (cnt_done) state_nx = ST_DECIDE;
            ST_DECIDE:  state_nx = ((nx_a != code_a) || (nx_b != code_b)) ? ST_SEND : ST_MEASURE;
            ST_SEND: begin
                gain.gain_valid = 1'b1;
                gain.gain_val   = pack_gain(code_b, code_a);
                if (gain.gain_ready)
                    state_nx = ST_SETTLE;
            end
            ST_SETTLE:  if (cnt_done) state_nx = ST_MEASURE;
            default:    state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_INIT;
            cnt    <= '0;
            code_a <= INIT_CODE;
            code_b <= INIT_CODE;
            peak_a <= '0;
            peak_b <= '0;
            update <= 1'b0;
        end else begin
            state  <= state_nx;
            update <= (state == ST_SEND) && gain.gain_ready;

            // One counter serves both the measurement window and the settle interval.
            if (!counting || cnt_done)
                cnt <= '0;
            else if (sample_valid)
                cnt <= cnt + 1'b1;

            if (state == ST_INIT) begin
                code_a <= INIT_CODE;
                code_b <= INIT_CODE;
            end else if (state == ST_DECIDE) begin
                code_a <= nx_a;
                code_b <= nx_b;
                peak_a <= acc_a;
                peak_b <= acc_b;
            end
        end
    end

endmodule

// File: tb/tb_ltc6912_agc.sv
// Directed bench for ltc6912_agc: reset hand-off, gain climb and step-down,
// clamps, window boundary and reset during a pending transfer.
module tb_ltc6912_agc;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic signed [11:0] sample_a, sample_b;
    logic [3:0]         code_a, code_b;
    logic [10:0]        peak_a, peak_b;
    logic               update;
    int                 errors = 0;
    int                 checks = 0;

    ltc6912_agc_if bus ();

    ltc6912_agc dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_a     (sample_a),
        .sample_b     (sample_b),
        .gain         (bus.master),
        .code_a       (code_a),
        .code_b       (code_b),
        .peak_a       (peak_a),
        .peak_b       (peak_b),
        .update       (update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples alternate sign around the base magnitude; one index may carry a spike.
    task automatic feed(input int n, input int base_a, input int base_b,
                        input int spike_idx, input int spike_a, input int spike_b);
        for (int i = 1; i <= n; i++) begin
            sample_valid = 1'b1;
            sample_a = 12'((i % 2 == 1) ? base_a : -base_a);
            sample_b = 12'((i % 2 == 1) ? base_b : -base_b);
            if (i == spike_idx && spike_a != 0) sample_a = 12'(spike_a);
            if (i == spike_idx && spike_b != 0) sample_b = 12'(spike_b);
            tick();
        end
        sample_valid = 1'b0;
        sample_a = '0;
        sample_b = '0;
    endtask

    task automatic settle();
        feed(64, 2000, 2000, 0, 0, 0);
        check("update_low_after_settle", update, 0);
    endtask

    task automatic window(input string tag, input int n, input int base_a, input int base_b,
                          input int spike_idx, input int spike_a, input int spike_b,
                          input bit chg, input int ea, input int eb, input int epa, input int epb);
        feed(n, base_a, base_b, spike_idx, spike_a, spike_b);
        tick();
        check({tag, "_valid"},  bus.gain_valid, chg);
        check({tag, "_code_a"}, code_a, ea);
        check({tag, "_code_b"}, code_b, eb);
        check({tag, "_peak_a"}, peak_a, epa);
        check({tag, "_peak_b"}, peak_b, epb);
        if (chg) begin
            check({tag, "_val"}, bus.gain_val, {eb[3:0], ea[3:0]});
            if (bus.gain_ready) begin
                tick();
                check({tag, "_update"}, update, 1);
                check({tag, "_valid_drop"}, bus.gain_valid, 0);
                settle();
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        sample_valid = 1'b0;
        sample_a = '0;
        sample_b = '0;
        bus.gain_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid",  bus.gain_valid, 0);
        check("rst_update", update, 0);
        check("rst_val",    bus.gain_val, 8'h00);
        check("rst_code_a", code_a, 1);
        check("rst_code_b", code_b, 1);
        check("rst_peak_a", peak_a, 0);
        check("rst_peak_b", peak_b, 0);

        reset = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("init_valid_hold", bus.gain_valid, 1);
            check("init_val_hold",   bus.gain_val, 8'h11);
            check("init_no_update",  update, 0);
            tick();
        end
        bus.gain_ready = 1'b1;
        tick();
        check("init_update",     update, 1);
        check("init_valid_drop", bus.gain_valid, 0);
        settle();

        // Quiet input: codes climb one step per window up to the clamp.
        for (int k = 2; k <= 7; k++)
            window("climb", 1024, 100, 100, 0, 0, 0, 1'b1, k, k, 100, 100);
        window("max_hold", 1024, 100, 100, 0, 0, 0, 1'b0, 7, 7, 100, 100);
        tick();
        check("max_hold_no_send", bus.gain_valid, 0);

        // Loud input steps both channels down to 4.
        for (int k = 6; k >= 4; k--)
            window("down", 1024, 2000, 2000, 0, 0, 0, 1'b1, k, k, 2000, 2000);

        window("split", 1024, 2000, 1000, 0, 0, 0, 1'b1, 3, 4, 2000, 1000);
        window("a_to_2", 1024, 2000, 1000, 0, 0, 0, 1'b1, 2, 4, 2000, 1000);
        window("a_to_1", 1024, 2000, 1000, 0, 0, 0, 1'b1, 1, 4, 2000, 1000);

        // Most negative sample saturates; code already at the lower clamp.
        window("neg_min", 1024, 100, 1000, 1, -2048, 0, 1'b0, 1, 4, 2047, 1000);

        // Spike as the last sample of a window is counted.
        window("spike_1024", 1024, 1000, 1000, 1024, 0, 2000, 1'b1, 1, 3, 1000, 2000);
        // Spike one sample past a window belongs to the next one.
        window("quiet_1024", 1024, 1000, 1000, 0, 0, 0, 1'b0, 1, 3, 1000, 1000);
        feed(1, 1000, 1000, 1, 0, 2000);
        bus.gain_ready = 1'b0;
        window("spike_1025", 1023, 1000, 1000, 0, 0, 0, 1'b1, 1, 2, 1000, 2000);

        for (int i = 0; i < 3; i++) begin
            tick();
            check("pend_valid", bus.gain_valid, 1);
            check("pend_val",   bus.gain_val, 8'h21);
        end
        reset = 1'b1;
        tick();
        check("midsend_valid",  bus.gain_valid, 0);
        check("midsend_code_a", code_a, 1);
        check("midsend_code_b", code_b, 1);
        check("midsend_update", update, 0);
        reset = 1'b0;
        tick();
        check("resend_valid", bus.gain_valid, 1);
        check("resend_val",   bus.gain_val, 8'h11);
        bus.gain_ready = 1'b1;
        tick();
        check("resend_update",     update, 1);
        check("resend_valid_drop", bus.gain_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
